alu_arbiter: RTL and testbench

//  Shares one 8-bit alu instance between two requesters (ports 0/1), round-robin.

---
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between two requesters.
// Optional feature macro: ALU_ARB_DIV0_EN (divide-by-zero forces y=8'hFF and raises err).
module alu_arbiter #(
    parameter int EXEC_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [2:0] op0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic [2:0] op1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] y,
    output logic       busy,
    output logic       err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYC - 1);

    logic [1:0] state_reg;
    logic [3:0] cnt_reg;
    logic       last_reg;
    logic       owner_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [2:0] op_reg;
    logic [7:0] y_reg;
    logic [1:0] done_reg;
    logic       busy_reg;

    logic       take;
    logic       pick;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [2:0] sel_op;
    logic [7:0] alu_out;

    // A grant can only be issued from IDLE; reset suppresses it so nothing is taken.
    always_comb begin
        take = 1'b0;
        pick = 1'b0;
        if (state_reg == IDLE && !rst) begin
            if (req0 && req1) begin
                take = 1'b1;
                pick = ~last_reg;
            end else if (req0) begin
                take = 1'b1;
                pick = 1'b0;
            end else if (req1) begin
                take = 1'b1;
                pick = 1'b1;
            end
        end
    end

    assign gnt0   = take & ~pick;
    assign gnt1   = take & pick;
    assign sel_a  = pick ? a1 : a0;
    assign sel_b  = pick ? b1 : b0;
    assign sel_op = pick ? op1 : op0;

    // The ALU only ever sees the latched operands, so they stay stable through EXEC.
    always_comb begin
        alu_out = 8'd0;
        case (op_reg)
            3'b000: alu_out = a_reg + b_reg;
            3'b001: alu_out = a_reg - b_reg;
            3'b010: alu_out = a_reg * b_reg;
            3'b011: alu_out = a_reg / b_reg;
            3'b100: alu_out = a_reg & b_reg;
            3'b101: alu_out = a_reg | b_reg;
            3'b110: alu_out = ~a_reg;
            3'b111: alu_out = a_reg ^ b_reg;
            default: alu_out = 8'd0;
        endcase
    end

`ifdef ALU_ARB_DIV0_EN
    logic div0_reg;
    logic err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            div0_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            if (take) begin
                div0_reg <= (sel_op == 3'b011) && (sel_b == 8'd0);
            end
            if (state_reg == EXEC && cnt_reg == 4'd0) begin
                err_reg <= div0_reg;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            last_reg  <= 1'b1;
            owner_reg <= 1'b0;
            a_reg     <= 8'd0;
            b_reg     <= 8'd0;
            op_reg    <= 3'd0;
            y_reg     <= 8'd0;
            done_reg  <= 2'b00;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 2'b00;
                    if (take) begin
                        a_reg     <= sel_a;
                        b_reg     <= sel_b;
                        op_reg    <= sel_op;
                        owner_reg <= pick;
                        last_reg  <= pick;
                        cnt_reg   <= CNT_INIT;
                        busy_reg  <= 1'b1;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
`ifdef ALU_ARB_DIV0_EN
                        y_reg <= div0_reg ? 8'hFF : alu_out;
`else
                        y_reg <= alu_out;
`endif
                        done_reg[owner_reg] <= 1'b1;
                        state_reg           <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 2'b00;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 2'b00;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign done0 = done_reg[0];
    assign done1 = done_reg[1];
    assign y     = y_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (EXEC_CYC=1 and 4) on shared stimulus, checked
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;

    logic       gnt0_o  [2];
    logic       gnt1_o  [2];
    logic       done0_o [2];
    logic       done1_o [2];
    logic [7:0] y_o     [2];
    logic       busy_o  [2];
    logic       err_o   [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        alu_arbiter #(.EXEC_CYC(gi == 0 ? 1 : 4)) dut (
            .clk  (clk),
            .rst  (rst),
            .req0 (req0),
            .a0   (a0),
            .b0   (b0),
            .op0  (op0),
            .req1 (req1),
            .a1   (a1),
            .b1   (b1),
            .op1  (op1),
            .gnt0 (gnt0_o[gi]),
            .gnt1 (gnt1_o[gi]),
            .done0(done0_o[gi]),
            .done1(done1_o[gi]),
            .y    (y_o[gi]),
            .busy (busy_o[gi]),
            .err  (err_o[gi])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Transaction-level model: a grant at cycle T occupies the ALU until T+E+1,
    // the result appears with done at T+E+1, and the next grant is possible at T+E+2.
    int exec_len [2] = '{1, 4};
    int cyc_n = 0;
    bit model_valid = 0;
    int free_at [2];
    int done_at [2];
    int owner   [2];
    int last_w  [2];
    int y_exp   [2];
    bit y_known [2];
    bit err_exp [2];
    int pend_y  [2];
    bit pend_known [2];
    bit pend_err   [2];

    function automatic int alu_ref(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            3: r = a / b;
            4: r = a & b;
            5: r = a | b;
            6: r = ~a;
            default: r = a ^ b;
        endcase
        return r & 255;
    endfunction

    task automatic model_cycle();
        for (int k = 0; k < 2; k++) begin
            int g = -1;
            if (cyc_n == done_at[k]) begin
                y_exp[k]   = pend_y[k];
                y_known[k] = pend_known[k];
                err_exp[k] = pend_err[k];
            end
            if (!rst && cyc_n >= free_at[k]) begin
                if (req0 && req1) g = (last_w[k] == 1) ? 0 : 1;
                else if (req0) g = 0;
                else if (req1) g = 1;
            end
            if (model_valid) begin
                check($sformatf("i%0d gnt0", k), 8'(gnt0_o[k]), 8'(g == 0));
                check($sformatf("i%0d gnt1", k), 8'(gnt1_o[k]), 8'(g == 1));
                check($sformatf("i%0d done0", k), 8'(done0_o[k]),
                      8'(cyc_n == done_at[k] && owner[k] == 0));
                check($sformatf("i%0d done1", k), 8'(done1_o[k]),
                      8'(cyc_n == done_at[k] && owner[k] == 1));
                check($sformatf("i%0d busy", k), 8'(busy_o[k]), 8'(cyc_n < free_at[k]));
                check($sformatf("i%0d err", k), 8'(err_o[k]), 8'(err_exp[k]));
                if (y_known[k]) check($sformatf("i%0d y", k), y_o[k], 8'(y_exp[k]));
            end
            if (g >= 0) begin
                int a  = (g == 1) ? int'(a1) : int'(a0);
                int b  = (g == 1) ? int'(b1) : int'(b0);
                int op = (g == 1) ? int'(op1) : int'(op0);
                bit div0 = (op == 3) && (b == 0);
`ifdef ALU_ARB_DIV0_EN
                pend_y[k]     = div0 ? 255 : alu_ref(a, b, op);
                pend_known[k] = 1;
                pend_err[k]   = div0;
`else
                pend_y[k]     = div0 ? 0 : alu_ref(a, b, op);
                pend_known[k] = !div0;
                pend_err[k]   = 0;
`endif
                last_w[k]  = g;
                owner[k]   = g;
                done_at[k] = cyc_n + exec_len[k] + 1;
                free_at[k] = cyc_n + exec_len[k] + 2;
            end
            if (rst) begin
                free_at[k] = cyc_n + 1;
                done_at[k] = -1;
                owner[k]   = 0;
                last_w[k]  = 1;
                y_exp[k]   = 0;
                y_known[k] = 1;
                err_exp[k] = 0;
            end
        end
        if (rst) model_valid = 1;
        cyc_n++;
    endtask

    task automatic nc();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic pc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            nc();
            pc();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    int n_done;
    int own_seq [4];
    int pulses;

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; op0 = 0;
        a1 = 0; b1 = 0; op1 = 0;
        for (int k = 0; k < 2; k++) begin
            free_at[k] = 0; done_at[k] = -1; owner[k] = 0; last_w[k] = 1;
            y_exp[k] = 0; y_known[k] = 1; err_exp[k] = 0;
            pend_y[k] = 0; pend_known[k] = 1; pend_err[k] = 0;
        end
        idle(2);
        rst = 1'b0;

        // Reset state
        nc();
        check("rst y", y_o[0], 8'd0);
        check("rst busy", 8'(busy_o[0]), 8'd0);
        check("rst done", 8'({done0_o[0], done1_o[0]}), 8'd0);
        check("rst err", 8'(err_o[0]), 8'd0);
        pc();

        // Single request: 7+3
        req0 = 1; a0 = 8'd7; b0 = 8'd3; op0 = 3'b000;
        nc();
        check("t2 gnt0", 8'(gnt0_o[0]), 8'd1);
        pc();
        req0 = 0;
        nc();
        pc();
        nc();
        check("t2 done0", 8'(done0_o[0]), 8'd1);
        check("t2 y", y_o[0], 8'd10);
        pc();
        idle(8);

        // Contention with both held high: 7-3 and 20*13 mod 256 are both 4
        do_reset();
        req0 = 1; a0 = 8'd7;  b0 = 8'd3;  op0 = 3'b001;
        req1 = 1; a1 = 8'd20; b1 = 8'd13; op1 = 3'b010;
        n_done = 0;
        own_seq = '{2, 2, 2, 2};
        repeat (20) begin
            nc();
            if (done0_o[0] || done1_o[0]) begin
                if (n_done < 4) own_seq[n_done] = done1_o[0] ? 1 : 0;
                n_done++;
                check("t3 y", y_o[0], 8'd4);
            end
            pc();
        end
        check("t3 ndone", 8'(n_done >= 4), 8'd1);
        check("t3 own0", 8'(own_seq[0]), 8'd0);
        check("t3 own1", 8'(own_seq[1]), 8'd1);
        check("t3 own2", 8'(own_seq[2]), 8'd0);
        check("t3 own3", 8'(own_seq[3]), 8'd1);
        req0 = 0; req1 = 0;
        idle(8);

        // Multi-cycle on the EXEC_CYC=4 instance; operand changes during EXEC are ignored
        do_reset();
        req1 = 1; a1 = 8'h0F; b1 = 8'hF0; op1 = 3'b111;
        nc();
        check("t4 gnt1", 8'(gnt1_o[1]), 8'd1);
        pc();
        req1 = 0; a1 = 8'h55; b1 = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            nc();
            if (i == 4) check("t4 early done1", 8'(done1_o[1]), 8'd0);
            if (i == 5) begin
                check("t4 done1", 8'(done1_o[1]), 8'd1);
                check("t4 y", y_o[1], 8'hFF);
            end
            pc();
        end
        idle(4);

        // Reset in the second EXEC cycle of the EXEC_CYC=4 instance
        do_reset();
        req0 = 1; a0 = 8'd1; b0 = 8'd2; op0 = 3'b000;
        nc();
        check("t5 gnt0", 8'(gnt0_o[1]), 8'd1);
        pc();
        req0 = 0;
        nc();
        pc();
        rst = 1;
        nc();
        pc();
        rst = 0;
        pulses = 0;
        repeat (8) begin
            nc();
            if (done0_o[1] || done1_o[1]) pulses++;
            pc();
        end
        check("t5 no done", 8'(pulses), 8'd0);
        req0 = 1; a0 = 8'd5; b0 = 8'd1; op0 = 3'b100;
        req1 = 1; a1 = 8'd6; b1 = 8'd3; op1 = 3'b101;
        nc();
        check("t5 tie gnt0", 8'(gnt0_o[1]), 8'd1);
        check("t5 tie gnt1", 8'(gnt1_o[1]), 8'd0);
        pc();
        req0 = 0; req1 = 0;
        idle(8);

        // Divide by zero, then a clean divide
        req0 = 1; a0 = 8'd9; b0 = 8'd0; op0 = 3'b011;
        nc();
        pc();
        req0 = 0;
        nc();
        pc();
        nc();
        check("t6 done0", 8'(done0_o[0]), 8'd1);
`ifdef ALU_ARB_DIV0_EN
        check("t6 div0 y", y_o[0], 8'hFF);
        check("t6 div0 err", 8'(err_o[0]), 8'd1);
`else
        check("t6 err off", 8'(err_o[0]), 8'd0);
`endif
        pc();
        idle(6);
        req0 = 1; a0 = 8'd9; b0 = 8'd2; op0 = 3'b011;
        nc();
        pc();
        req0 = 0;
        nc();
        pc();
        nc();
        check("t6 div y", y_o[0], 8'd4);
        check("t6 div err", 8'(err_o[0]), 8'd0);
        pc();
        idle(6);

        // Randomized traffic with occasional reset
        repeat (3000) begin
            rst  = ($urandom_range(0, 99) == 0);
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            a0   = 8'($urandom);
            a1   = 8'($urandom);
            b0   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            b1   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            op0  = 3'($urandom);
            op1  = 3'($urandom);
            nc();
            pc();
        end
        rst = 0; req0 = 0; req1 = 0;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
